freq_mon: RTL and testbench
===========================

FREQ_MON -- requirements
Module: freq_mon

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of period/high-time counters.
REQ-002 The block SHALL have parameter LOCK_CNT, default 4, giving the number of consecutive good periods required to lock.
REQ-003 The block SHALL have port clk_in  input  1  single system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  monitor enable.
REQ-006 The block SHALL have port div_in  input  4  divided clocks: bit0 div-by-2, bit1 div-by-3, bit2 div-by-4, bit3 div-by-5, all derived from clk_in.
REQ-007 The block SHALL have port clr_err  input  1  clears sticky errors.
REQ-008 The block SHALL have port sel  input  2  channel selected for readback.
REQ-009 The block SHALL have port lock  output  4  per-channel locked flag.
REQ-010 The block SHALL have port err  output  4  per-channel sticky error flag.
REQ-011 The block SHALL have port period_out  output  CNT_W  last measured period of the selected channel, in clk_in cycles.
REQ-012 The block SHALL have port high_out  output  CNT_W  last measured high time of the selected channel, in clk_in cycles.

Function
REQ-013 Each channel SHALL register div_in[i] once; rise = current & ~previous registered sample.
REQ-014 Expected period for channel i SHALL be N = i+2 clk_in cycles.
REQ-015 Channel FSM SHALL use states IDLE, WAIT_EDGE, MEASURE and LOCKED.
REQ-016 IDLE -> WAIT_EDGE when en=1; any state -> IDLE when en=0.
REQ-017 WAIT_EDGE -> MEASURE on first rise; the period counter loads 1.
REQ-018 In MEASURE/LOCKED the period counter SHALL increment each cycle, saturating at 2^CNT_W-1; high counter increments while the sample is 1.
REQ-019 On each subsequent rise, the period SHALL be good if count == N (and the duty check passes, REQ-032); counters then reload.
REQ-020 A good period SHALL increment the good-count; reaching LOCK_CNT moves MEASURE -> LOCKED and sets lock[i].
REQ-021 A bad period SHALL clear the good-count and lock[i], set err[i], and move to MEASURE.
REQ-022 Timeout: when the count reaches 2N without a rise, the channel SHALL set err[i], clear lock[i] and move to WAIT_EDGE.
REQ-023 lock/err updates SHALL be visible on the clock edge after the cycle in which the rise or timeout is detected (1-cycle latency).
REQ-024 period_out/high_out SHALL be registered copies of the last completed measurement, muxed by sel combinationally.
REQ-025 clr_err SHALL clear all err bits; a new error in the same cycle SHALL win, leaving that bit set.
REQ-026 en=0 SHALL clear lock and counters but hold err and the last measurements.

Reset
REQ-027 rst=1 SHALL asynchronously force all FSMs to IDLE, and clear lock, err, period_out, high_out, counters and sample flops to 0.
REQ-028 Reset asserted mid-measurement SHALL discard the partial period; after release, measurement restarts from WAIT_EDGE.

Configuration
REQ-029 Macro FREQ_MON_DUTY_EN SHALL compile the duty check in.
REQ-030 With FREQ_MON_DUTY_EN defined, high count SHALL lie in [floor(N/2), ceil(N/2)] for a good period.
REQ-031 Without FREQ_MON_DUTY_EN, the high counters SHALL be absent, high_out SHALL be tied to 0, and only the period is checked.
REQ-032 The duty check SHALL apply only when FREQ_MON_DUTY_EN is defined.

Structure
REQ-033 Package freq_mon_pkg SHALL hold the channel-state enum, NCH=4, and the expected-ratio constants.
REQ-034 Sub-module freq_mon_ch SHALL implement one channel (sampler, counters, FSM); the top SHALL instantiate four of them, plus the err/clr logic and the readback mux.

Verification
REQ-035 Drive div_in from correct dividers with en=1 after reset -> lock=4'b1111 by cycle 40, err=0, sel=3 gives period_out=5.
REQ-036 After lock, make one ch1 period 4 cycles -> err[1]=1 and lock[1]=0 one cycle after that rise; lock[1] returns after 4 good periods while err[1] stays 1.
REQ-037 After lock, hold div_in[2]=0 -> 8 cycles after the last rise, err[2]=1 and lock[2]=0.
REQ-038 Pulse clr_err in the same cycle as a ch0 bad period -> err[0] remains 1; a later clr_err alone clears it.
REQ-039 Assert rst mid-period -> all outputs 0 immediately, without waiting for a clock; after release, relock as in REQ-035.
REQ-040 Drop en after lock -> lock=0 next cycle, err and period_out unchanged.

Source files
------------

// File: rtl/freq_mon_pkg.sv
// freq_mon_pkg: shared channel-state encoding, channel count and the
// expected divide ratio of each monitored clock.
package freq_mon_pkg;

    localparam int NCH        = 4;
    // Channel 0 is div-by-2; each following channel divides by one more.
    localparam int BASE_RATIO = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_LOCKED    = 2'd3
    } ch_state_e;

    // Expected period, in clk_in cycles, of monitored channel ch.
    function automatic int exp_period(input int ch);
        return BASE_RATIO + ch;
    endfunction

endpackage

// File: rtl/freq_mon_ch.sv
// freq_mon_ch: one monitor channel -- input sampler, period counter and
// lock FSM. Emits a one-cycle err_evt_o for every bad period or timeout.
// Optional duty check, compiled in with FREQ_MON_DUTY_EN.
module freq_mon_ch
    import freq_mon_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int N        = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en_i,
    input  logic             div_i,
    output logic             lock_o,
    output logic             err_evt_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o
);

    // Good-count only has to reach LOCK_CNT-1; the next good period locks.
    localparam int               GOOD_W    = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_GOOD  = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_TMO   = CNT_W'(2 * N);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    ch_state_e         state_q, state_d;
    logic              samp_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic rise, active, start, close, timeout, duty_ok, period_good;

    assign rise        = div_i & ~samp_q;
    assign active      = en_i && (state_q == ST_MEASURE || state_q == ST_LOCKED);
    assign start       = en_i && (state_q == ST_WAIT_EDGE) && rise;
    assign close       = active && rise;
    // A rise in the timeout cycle still closes the period (as a bad one).
    assign timeout     = active && !rise && (cnt_q == CNT_TMO);
    assign period_good = (cnt_q == CNT_GOOD) && duty_ok;
    assign err_evt_o   = (close && !period_good) || timeout;
    assign lock_o      = (state_q == ST_LOCKED);
    assign period_o    = period_q;

    // FSM and period-counter next state.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        good_d   = good_q;
        period_d = period_q;
        if (!en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            good_d  = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_WAIT_EDGE;
        end else if (start) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
        end else if (close) begin
            period_d = cnt_q;
            cnt_d    = CNT_ONE;
            if (!period_good) begin
                good_d  = '0;
                state_d = ST_MEASURE;
            end else if (state_q == ST_MEASURE) begin
                if (good_q == GOOD_LAST) state_d = ST_LOCKED;
                else                     good_d  = good_q + 1'b1;
            end
        end else if (timeout) begin
            state_d = ST_WAIT_EDGE;
            cnt_d   = '0;
            good_d  = '0;
        end else if (active && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Channel state registers; reset discards any partial period.
    always_ff @(posedge clk_in or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q  <= ST_IDLE;
            samp_q   <= 1'b0;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            samp_q   <= div_i;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
        end
    end

`ifdef FREQ_MON_DUTY_EN
    localparam logic [CNT_W-1:0] HIGH_MIN = CNT_W'(N / 2);
    localparam logic [CNT_W-1:0] HIGH_MAX = CNT_W'((N + 1) / 2);

    logic [CNT_W-1:0] hcnt_q, hcnt_d, high_q;

    assign duty_ok = (hcnt_q >= HIGH_MIN) && (hcnt_q <= HIGH_MAX);
    assign high_o  = high_q;

    // High-time counter; the rise cycle itself is the first high cycle.
    always_comb begin
        hcnt_d = hcnt_q;
        if (!en_i || timeout)                       hcnt_d = '0;
        else if (start || close)                    hcnt_d = CNT_ONE;
        else if (active && div_i && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 1'b1;
    end

    // High-time registers; the measurement is captured when a period closes.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            if (close) high_q <= hcnt_q;
        end
    end
`else
    assign duty_ok = 1'b1;
    assign high_o  = '0;
`endif

endmodule

// File: rtl/freq_mon.sv
// freq_mon: monitors four divided clocks of clk_in, reporting per-channel
// lock, sticky error and a selectable readback of the last measurement.
// Build option: FREQ_MON_DUTY_EN adds a duty-cycle check to each channel.
module freq_mon
    import freq_mon_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   div_in,
    input  logic             clr_err,
    input  logic [1:0]       sel,
    output logic [NCH-1:0]   lock,
    output logic [NCH-1:0]   err,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out
);

    logic [NCH-1:0]   err_evt;
    logic [NCH-1:0]   err_q, err_d;
    logic [CNT_W-1:0] ch_period [NCH];
    logic [CNT_W-1:0] ch_high   [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        freq_mon_ch #(
            .CNT_W    (CNT_W),
            .LOCK_CNT (LOCK_CNT),
            .N        (exp_period(i))
        ) u_ch (
            .clk_in    (clk_in),
            .rst       (rst),
            .en_i      (en),
            .div_i     (div_in[i]),
            .lock_o    (lock[i]),
            .err_evt_o (err_evt[i]),
            .period_o  (ch_period[i]),
            .high_o    (ch_high[i])
        );
    end

    // A new error in the clear cycle wins, so OR the events in after clearing.
    assign err_d = (err_q & ~{NCH{clr_err}}) | err_evt;

    // Sticky error flags.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign err        = err_q;
    assign period_out = ch_period[sel];
    assign high_out   = ch_high[sel];

endmodule

// File: tb/tb_freq_mon.sv
// tb_freq_mon: directed scenarios plus a randomized tail, checked every
// cycle against a timestamp-based reference model of the monitor rules.
module tb_freq_mon;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;

    logic             clk_in = 1'b0;
    logic             rst, en, clr_err;
    logic [3:0]       div_in;
    logic [1:0]       sel;
    logic [3:0]       lock, err;
    logic [CNT_W-1:0] period_out, high_out;

    freq_mon #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .clr_err    (clr_err),
        .sel        (sel),
        .lock       (lock),
        .err        (err),
        .period_out (period_out),
        .high_out   (high_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divider generators: channel i nominally has period i+2, high for hi[i].
    int         ph [4];
    int         len[4];
    int         hi [4];
    bit         stuck[4];
    logic [3:0] div_next;

    task automatic gen_div();
        for (int i = 0; i < 4; i++) begin
            div_next[i] = !stuck[i] && (ph[i] < hi[i]);
            ph[i]++;
            if (ph[i] >= len[i]) begin
                ph[i]  = 0;
                len[i] = i + 2;
            end
        end
    endtask

    // Reference model: mode 0 off, 1 waiting for a first rise, 2 timing.
    int         mmode[4];
    int         mlast[4];
    int         mgood[4];
    logic [3:0] lock_m, err_m, prev_m;
    logic [7:0] per_m[4];
    int         cyc;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mmode[i] = 0;
            mlast[i] = 0;
            mgood[i] = 0;
            per_m[i] = '0;
        end
        lock_m = '0;
        err_m  = '0;
        prev_m = '0;
    endtask

    task automatic model_edge();
        logic [3:0] new_err;
        bit         r;
        int         p;
        new_err = '0;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                r = div_in[i] && !prev_m[i];
                prev_m[i] = div_in[i];
                if (!en) begin
                    mmode[i]  = 0;
                    lock_m[i] = 1'b0;
                    mgood[i]  = 0;
                end else if (mmode[i] == 0) begin
                    mmode[i] = 1;
                end else if (mmode[i] == 1) begin
                    if (r) begin
                        mmode[i] = 2;
                        mlast[i] = cyc;
                    end
                end else begin
                    p = cyc - mlast[i];
                    if (r) begin
                        per_m[i] = 8'(p);
                        mlast[i] = cyc;
                        if (p == i + 2) begin
                            mgood[i]++;
                            if (mgood[i] >= LOCK_CNT) lock_m[i] = 1'b1;
                        end else begin
                            new_err[i] = 1'b1;
                            mgood[i]   = 0;
                            lock_m[i]  = 1'b0;
                        end
                    end else if (p == 2 * (i + 2)) begin
                        new_err[i] = 1'b1;
                        mgood[i]   = 0;
                        lock_m[i]  = 1'b0;
                        mmode[i]   = 1;
                    end
                end
            end
            err_m = (err_m & ~{4{clr_err}}) | new_err;
        end
        cyc++;
    endtask

    task automatic compare_all();
        check("lock", lock, lock_m);
        check("err", err, err_m);
        check("period_out", period_out, per_m[sel]);
`ifndef FREQ_MON_DUTY_EN
        check("high_out", high_out, 0);
`endif
    endtask

    // One clk_in cycle: inputs are set before the edge, outputs sampled at negedge.
    task automatic tick();
        gen_div();
        div_in = div_next;
        sel    = 2'($urandom_range(0, 3));
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        compare_all();
    endtask

    initial begin
        logic [3:0] err_s;
        bit         hit;
        bit         pv;
        rst = 1'b0; en = 1'b0; clr_err = 1'b0; sel = '0; div_in = '0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            len[i]   = i + 2;
            ph[i]    = $urandom_range(0, i + 1);
            hi[i]    = $urandom_range((i + 2) / 2, (i + 3) / 2);
            stuck[i] = 1'b0;
        end
        model_reset();

        // Reset state.
        #1 rst = 1'b1;
        #1;
        check("rst_lock", lock, 0);
        check("rst_err", err, 0);
        check("rst_period", period_out, 0);
        check("rst_high", high_out, 0);
        repeat (2) tick();
        rst = 1'b0;
        en  = 1'b1;

        // Correct dividers lock every channel within 40 cycles.
        repeat (40) tick();
        check("lock_all", lock, 4'hF);
        check("err_none", err, 0);
        sel = 2'd3;
        #1 check("period_ch3", period_out, 5);

        // One 4-cycle period on ch1: error, drop lock, relock after 4 good.
        len[1] = 4;
        repeat (30) tick();
        check("ch1_err_sticky", err[1], 1);
        check("ch1_relock", lock[1], 1);

        // clr_err alone clears everything.
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_alone", err, 0);

        // clr_err coincident with a bad ch0 period: the new error wins.
        len[0] = 3;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            pv = !stuck[0] && (ph[0] < hi[0]);
            if (pv && !prev_m[0] && mmode[0] == 2 && en && (cyc - mlast[0]) != 2) begin
                clr_err = 1'b1;
                hit     = 1'b1;
            end
            tick();
            clr_err = 1'b0;
        end
        check("ch0_bad_found", hit, 1);
        check("ch0_err_wins", err[0], 1);
        repeat (3) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ch0_err_cleared", err[0], 0);

        // ch2 held low: timeout error and lock loss, then recovery.
        stuck[2] = 1'b1;
        repeat (12) tick();
        check("ch2_tmo_err", err[2], 1);
        check("ch2_tmo_lock", lock[2], 0);
        stuck[2] = 1'b0;
        repeat (25) tick();
        check("ch2_relock", lock[2], 1);

        // Dropping en clears lock but holds err and measurements.
        err_s = err_m;
        en = 1'b0;
        tick();
        check("en_off_lock", lock, 0);
        check("en_off_err", err, err_s);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1 check("en_off_period", period_out, s + 2);
        end
        en = 1'b1;
        repeat (30) tick();
        check("en_on_relock", lock, 4'hF);

        // Reset mid-period clears all outputs without a clock edge.
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_lock", lock, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_period", period_out, 0);
        check("mid_rst_high", high_out, 0);
        @(negedge clk_in);
        repeat (2) tick();
        rst = 1'b0;
        repeat (40) tick();
        check("post_rst_lock", lock, 4'hF);
        check("post_rst_err", err, 0);
        sel = 2'd3;
        #1 check("post_rst_period", period_out, 5);

        // Randomized tail: period glitches, stuck inputs, en toggles, clears.
        repeat (400) begin
            if ($urandom_range(0, 39) == 0) begin
                int c;
                c = $urandom_range(0, 3);
                len[c] = $urandom_range(1, 2 * (c + 2) + 2);
            end
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 199) == 0) stuck[i] = !stuck[i];
            if ($urandom_range(0, 99) == 0) en = !en;
            clr_err = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
